// File: rtl/ibus_initiator.sv
// ibus_initiator: single-outstanding IBUS master turning host byte/word/long commands into bus cycles.
// Optional busy timeout is compiled in when IBUS_TIMEOUT_EN is defined.
module ibus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_r,
  input  logic        ce_f,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_wd,
  input  logic [1:0]  cmd_sz,
  input  logic        cmd_we,
  input  logic        cmd_sext,
  input  logic        cmd_req,
  output logic        cmd_ack,
  output logic        cmd_err,
  output logic [31:0] cmd_rd,
  output logic [31:0] ibus_a,
  output logic [31:0] ibus_di,
  input  logic [31:0] ibus_do,
  output logic [3:0]  ibus_ba,
  output logic        ibus_we,
  output logic        ibus_req,
  input  logic        ibus_busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  state_e state_q, state_d;

  logic        cmd_legal;
  logic [3:0]  cmd_ba;
  logic [31:0] cmd_di;
  logic [7:0]  lane_byte;
  logic [15:0] lane_word;
  logic [31:0] lane_rd;
  logic        timeout;
  logic [1:0]  sz_q, sz_d;
  logic        sext_q, sext_d;
  logic [31:0] a_d, di_d, rd_d;
  logic [3:0]  ba_d;
  logic        we_d, req_d, ack_d, err_d;

  // ce_f is only present so every bus agent shares the same port set.
  logic unused_ce_f;
  assign unused_ce_f = ce_f;

  // Command decode: lane enables, replicated write data and alignment legality.
  always_comb begin
    cmd_legal = 1'b0;
    cmd_ba    = 4'b0000;
    cmd_di    = 32'h0;
    unique case (cmd_sz)
      2'b00: begin
        cmd_legal = 1'b1;
        cmd_ba    = 4'b1000 >> cmd_a[1:0];
        cmd_di    = {4{cmd_wd[7:0]}};
      end
      2'b01: begin
        cmd_legal = ~cmd_a[0];
        cmd_ba    = cmd_a[1] ? 4'b0011 : 4'b1100;
        cmd_di    = {2{cmd_wd[15:0]}};
      end
      2'b10: begin
        cmd_legal = (cmd_a[1:0] == 2'b00);
        cmd_ba    = 4'b1111;
        cmd_di    = cmd_wd;
      end
      default: ;
    endcase
  end

  // Big-endian lane extraction, right-justified with optional sign extension.
  always_comb begin
    lane_byte = ibus_do[31:24];
    case (ibus_a[1:0])
      2'd1:    lane_byte = ibus_do[23:16];
      2'd2:    lane_byte = ibus_do[15:8];
      2'd3:    lane_byte = ibus_do[7:0];
      default: ;
    endcase
    lane_word = ibus_a[1] ? ibus_do[15:0] : ibus_do[31:16];
    lane_rd   = ibus_do;
    case (sz_q)
      2'b00:   lane_rd = {{24{sext_q & lane_byte[7]}}, lane_byte};
      2'b01:   lane_rd = {{16{sext_q & lane_word[15]}}, lane_word};
      default: ;
    endcase
  end

`ifdef IBUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts busy ticks in ACCESS; anywhere else it is held at zero so entry starts clean.
  assign cnt_d   = (state_q == StAccess && ibus_busy) ? cnt_q + 16'd1 : 16'd0;
  assign timeout = ibus_busy && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (ce_r) begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (ce_r) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_req) state_d = cmd_legal ? StAccess : StDone;
      StAccess: if (!ibus_busy || timeout) state_d = StDone;
      StDone:   if (!cmd_req) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d    = ibus_a;
    di_d   = ibus_di;
    ba_d   = ibus_ba;
    we_d   = ibus_we;
    req_d  = ibus_req;
    ack_d  = cmd_ack;
    err_d  = cmd_err;
    rd_d   = cmd_rd;
    sz_d   = sz_q;
    sext_d = sext_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_req && cmd_legal) begin
          a_d    = cmd_a;
          ba_d   = cmd_ba;
          we_d   = cmd_we;
          req_d  = 1'b1;
          sz_d   = cmd_sz;
          sext_d = cmd_sext;
          if (cmd_we) di_d = cmd_di;
        end else if (cmd_req) begin
          ack_d = 1'b1;
          err_d = 1'b1;
          rd_d  = 32'h0;
        end
      end
      StAccess: begin
        if (!ibus_busy) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          ack_d = 1'b1;
          err_d = 1'b0;
          if (!ibus_we) rd_d = lane_rd;
        end else if (timeout) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          ack_d = 1'b1;
          err_d = 1'b1;
          rd_d  = 32'h0;
        end
      end
      StDone: begin
        if (!cmd_req) begin
          ack_d = 1'b0;
          err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ibus_a   <= 32'h0;
      ibus_di  <= 32'h0;
      ibus_ba  <= 4'h0;
      ibus_we  <= 1'b0;
      ibus_req <= 1'b0;
      cmd_ack  <= 1'b0;
      cmd_err  <= 1'b0;
      cmd_rd   <= 32'h0;
      sz_q     <= 2'b00;
      sext_q   <= 1'b0;
    end else if (ce_r) begin
      ibus_a   <= a_d;
      ibus_di  <= di_d;
      ibus_ba  <= ba_d;
      ibus_we  <= we_d;
      ibus_req <= req_d;
      cmd_ack  <= ack_d;
      cmd_err  <= err_d;
      cmd_rd   <= rd_d;
      sz_q     <= sz_d;
      sext_q   <= sext_d;
    end
  end

endmodule

// File: tb/tb_ibus_initiator.sv
// Bench for ibus_initiator: table of host commands checked through a result scoreboard,
// plus hand sequences for CE_R gating, stuck BUSY and reset during an access.
module tb_ibus_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_r, ce_f;
  logic [31:0] cmd_a, cmd_wd, cmd_rd;
  logic [1:0]  cmd_sz;
  logic        cmd_we, cmd_sext, cmd_req, cmd_ack, cmd_err;
  logic [31:0] ibus_a, ibus_di, ibus_do;
  logic [3:0]  ibus_ba;
  logic        ibus_we, ibus_req, ibus_busy;

  always #5 clk = ~clk;

  ibus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ce_r(ce_r), .ce_f(ce_f),
    .cmd_a(cmd_a), .cmd_wd(cmd_wd), .cmd_sz(cmd_sz), .cmd_we(cmd_we),
    .cmd_sext(cmd_sext), .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_err(cmd_err),
    .cmd_rd(cmd_rd), .ibus_a(ibus_a), .ibus_di(ibus_di), .ibus_do(ibus_do),
    .ibus_ba(ibus_ba), .ibus_we(ibus_we), .ibus_req(ibus_req), .ibus_busy(ibus_busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] dout;
    logic [1:0]  sz;
    logic        we;
    logic        sext;
    int          busy;
    logic [3:0]  ba;
    logic [31:0] di;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t        vecs[14];
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] rd_model = 32'h0;
  logic [31:0] di_model = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input vec_t v);
    exp_t e;
    int   busy_left, req_ticks, ack_at;
    busy_left = v.busy;
    req_ticks = 0;
    ack_at    = -1;
    e.err = v.err;
    e.rd  = v.err ? 32'h0 : (v.we ? rd_model : v.rd);
    sb.push_back(e);
    cmd_a = v.a; cmd_wd = v.wd; cmd_sz = v.sz; cmd_we = v.we; cmd_sext = v.sext;
    ibus_do = v.dout; ibus_busy = 1'b0; cmd_req = 1'b1;
    for (int c = 0; c < 40 && ack_at < 0; c++) begin
      @(negedge clk);
      if (ibus_req) begin
        req_ticks++;
        if (req_ticks == 1) begin
          check("bus_we", {31'h0, ibus_we}, {31'h0, v.we});
          // Inputs must be ignored once the access is launched.
          cmd_a = ~v.a; cmd_wd = ~v.wd; cmd_sz = ~v.sz; cmd_we = ~v.we; cmd_sext = ~v.sext;
        end
        check("bus_a", ibus_a, v.a);
        check("bus_ba", {28'h0, ibus_ba}, {28'h0, v.ba});
        ibus_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end
      if (cmd_ack) ack_at = c;
    end
    ibus_busy = 1'b0;
    check("ack_latency", ack_at, v.err ? 0 : v.busy + 1);
    check("req_ticks", req_ticks, v.err ? 0 : v.busy + 1);
    if (sb.size() > 0) e = sb.pop_front();
    check("rd", cmd_rd, e.rd);
    check("err", {31'h0, cmd_err}, {31'h0, e.err});
    rd_model = e.rd;
    if (!v.err) begin
      if (v.we) di_model = v.di;
      check("bus_di", ibus_di, di_model);
      check("bus_we_idle", {31'h0, ibus_we}, 32'h0);
    end
    repeat (2) begin
      @(negedge clk);
      check("ack_hold", {30'h0, cmd_ack, ibus_req}, 32'h2);
    end
    cmd_req = 1'b0;
    @(negedge clk);
    check("ack_clear", {30'h0, cmd_ack, cmd_err}, 32'h0);
    check("rd_hold", cmd_rd, rd_model);
  endtask

  initial begin
    int seen, req_cnt, ack_cnt, ack_at;
    //            a             wd            dout          sz    we    sext busy ba       di            rd            err
    vecs[0]  = '{32'hFFFFFE10, 32'h12345678, 32'h0,        2'b10, 1'b1, 1'b0, 0, 4'b1111, 32'h12345678, 32'h0,        1'b0};
    vecs[1]  = '{32'hFFFFFE11, 32'h0,        32'h00AB0000, 2'b00, 1'b0, 1'b0, 0, 4'b0100, 32'h0,        32'h000000AB, 1'b0};
    vecs[2]  = '{32'hFFFFFE11, 32'h0,        32'h00AB0000, 2'b00, 1'b0, 1'b1, 0, 4'b0100, 32'h0,        32'hFFFFFFAB, 1'b0};
    vecs[3]  = '{32'hFFFFFE13, 32'h000000C3, 32'h0,        2'b00, 1'b1, 1'b0, 0, 4'b0001, 32'hC3C3C3C3, 32'h0,        1'b0};
    vecs[4]  = '{32'hFFFFFE12, 32'h0,        32'h00008001, 2'b01, 1'b0, 1'b0, 3, 4'b0011, 32'h0,        32'h00008001, 1'b0};
    vecs[5]  = '{32'hFFFFFE12, 32'h0,        32'h00008001, 2'b01, 1'b0, 1'b1, 3, 4'b0011, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[6]  = '{32'hFFFFFE11, 32'h0,        32'h0,        2'b01, 1'b0, 1'b0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{32'hFFFFFE10, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{32'hFFFFFE10, 32'h0000BEEF, 32'h0,        2'b01, 1'b1, 1'b0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0};
    vecs[9]  = '{32'hFFFFFE14, 32'h0,        32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 2, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[10] = '{32'hFFFFFE12, 32'h0,        32'h0,        2'b10, 1'b0, 1'b0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{32'hFFFFFE10, 32'h0,        32'h80000000, 2'b00, 1'b0, 1'b1, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[12] = '{32'hFFFFFE10, 32'h0,        32'h7FFF1234, 2'b01, 1'b0, 1'b1, 0, 4'b1100, 32'h0,        32'h00007FFF, 1'b0};
    vecs[13] = '{32'hFFFFFE12, 32'h0,        32'h12345678, 2'b00, 1'b0, 1'b1, 1, 4'b0010, 32'h0,        32'h00000056, 1'b0};

    ce_r = 1'b1; ce_f = 1'b0; cmd_a = 32'h0; cmd_wd = 32'h0; cmd_sz = 2'b00;
    cmd_we = 1'b0; cmd_sext = 1'b0; cmd_req = 1'b0; ibus_do = 32'h0; ibus_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ack_err_we", {28'h0, ibus_req, cmd_ack, cmd_err, ibus_we}, 32'h0);
    check("rst_a", ibus_a, 32'h0);
    check("rst_di", ibus_di, 32'h0);
    check("rst_ba", {28'h0, ibus_ba}, 32'h0);
    check("rst_rd", cmd_rd, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Without CE_R nothing advances even with a legal command pending.
    ce_r = 1'b0; cmd_a = 32'hFFFFFE10; cmd_sz = 2'b10; cmd_req = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | int'(ibus_req) | int'(cmd_ack);
    end
    check("ce_r_gate", seen, 0);
    cmd_req = 1'b0; ce_r = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) do_cmd(vecs[i]);

    // BUSY stuck high: without the timeout option the access waits indefinitely.
    cmd_a = 32'hFFFFFE20; cmd_sz = 2'b10; cmd_we = 1'b0; cmd_sext = 1'b0;
    ibus_do = 32'hCAFEF00D; ibus_busy = 1'b1; cmd_req = 1'b1;
    req_cnt = 0; ack_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      req_cnt += int'(ibus_req);
      ack_cnt += int'(cmd_ack);
    end
    check("stuck_busy_req", req_cnt, 30);
    check("stuck_busy_ack", ack_cnt, 0);

    // Asynchronous reset between clock edges, then the held request re-issues.
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", {29'h0, ibus_req, cmd_ack, cmd_err}, 32'h0);
    check("async_rst_a", ibus_a, 32'h0);
    @(negedge clk);
    rst = 1'b0; ibus_busy = 1'b0;
    ack_at = -1;
    for (int c = 0; c < 10 && ack_at < 0; c++) begin
      @(negedge clk);
      if (cmd_ack) ack_at = c;
    end
    check("reissue_latency", ack_at, 1);
    check("reissue_rd", cmd_rd, 32'hCAFEF00D);
    check("reissue_err", {31'h0, cmd_err}, 32'h0);
    check("reissue_a", ibus_a, 32'hFFFFFE20);
    cmd_req = 1'b0;
    @(negedge clk);
    check("reissue_clear", {31'h0, cmd_ack}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
